// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: turns one EXU request into a single aligned data-memory access
// and returns the extended load result (or an error) to the WBU.
module ysyx_23060201_lsu #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_wen,
  input  logic [2:0]                in_funct3,
  input  logic [MEM_ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_rdata,
  output logic                      out_err,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]                mem_wmask,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]                mem_rmask,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    wen_r;
  logic [2:0]              funct3_r;
  logic [1:0]              off_r;
  logic                    req_err_s;
  logic [3:0]              req_mask_s;
  logic [DATA_WIDTH-1:0]   ld_data_s;

  function automatic logic illegal_op(input logic wen, input logic [2:0] f3);
    if (wen) begin
      return f3 > 3'b010;
    end else begin
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
  endfunction

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [1:0] off,
                                                        input logic [DATA_WIDTH-1:0] rdata);
    logic [DATA_WIDTH-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'b001:  return {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      3'b010:  return sh;
      default: return {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  // Request decode from live inputs and load extraction from the captured request
  always_comb begin
    req_err_s  = illegal_op(in_wen, in_funct3) || misaligned(in_funct3, in_addr[1:0]);
    req_mask_s = byte_mask(in_funct3, in_addr[1:0]);
    ld_data_s  = load_extend(funct3_r, off_r, mem_rdata);
  end

  // Control FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      wen_r     <= 1'b0;
      funct3_r  <= 3'b000;
      off_r     <= 2'b00;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_rdata <= {DATA_WIDTH{1'b0}};
      out_err   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_waddr <= {MEM_ADDR_WIDTH{1'b0}};
      mem_raddr <= {MEM_ADDR_WIDTH{1'b0}};
      mem_wmask <= 8'h00;
      mem_rmask <= 8'h00;
      mem_wdata <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            wen_r    <= in_wen;
            funct3_r <= in_funct3;
            off_r    <= in_addr[1:0];
            in_ready <= 1'b0;
            if (req_err_s) begin
              state_r   <= RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= {DATA_WIDTH{1'b0}};
            end else begin
              state_r   <= ISSUE;
              mem_wen   <= in_wen;
              mem_ren   <= ~in_wen;
              mem_waddr <= {in_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
              mem_raddr <= {in_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
              mem_wmask <= {4'b0000, req_mask_s};
              mem_rmask <= {4'b0000, req_mask_s};
              mem_wdata <= in_wen ? (in_wdata << {in_addr[1:0], 3'b000}) : {DATA_WIDTH{1'b0}};
            end
          end
        end
        ISSUE: begin
          // mem_rdata is only valid during this cycle, so the result is latched now
          state_r   <= RESP;
          out_valid <= 1'b1;
          out_err   <= 1'b0;
          out_rdata <= wen_r ? {DATA_WIDTH{1'b0}} : ld_data_s;
          mem_wen   <= 1'b0;
          mem_ren   <= 1'b0;
          mem_waddr <= {MEM_ADDR_WIDTH{1'b0}};
          mem_raddr <= {MEM_ADDR_WIDTH{1'b0}};
          mem_wmask <= 8'h00;
          mem_rmask <= 8'h00;
          mem_wdata <= {DATA_WIDTH{1'b0}};
        end
        RESP: begin
          if (out_ready) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          out_rdata <= {DATA_WIDTH{1'b0}};
          mem_wen   <= 1'b0;
          mem_ren   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Self-checking bench for ysyx_23060201_lsu: directed spec cases plus random
// requests compared against an arithmetic reference model.
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_waddr, mem_raddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask, mem_rmask;

  int errors = 0;
  int checks = 0;

  logic        cur_wen;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr, cur_wdata, cur_word;
  logic        exp_err;
  logic [31:0] exp_rdata, exp_wdata, exp_aligned;
  logic [7:0]  exp_mask;
  logic [31:0] hold_rdata;

  ysyx_23060201_lsu #(.MEM_ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rmask(mem_rmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference model: access size, legality and extension by plain arithmetic
  task automatic compute_model();
    longint unsigned size, off, v, val, bits;
    logic legal;
    size = (cur_f3[1:0] == 2'd0) ? 64'd1 : (cur_f3[1:0] == 2'd1) ? 64'd2 : 64'd4;
    if (cur_wen) legal = (cur_f3 <= 3'd2);
    else         legal = (cur_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    exp_err     = !legal || ((64'(cur_addr) % size) != 64'd0);
    off         = 64'(cur_addr) % 64'd4;
    exp_aligned = 32'(64'(cur_addr) - off);
    exp_mask    = 8'(((64'd2 ** size) - 64'd1) * (64'd2 ** off));
    exp_wdata   = 32'(64'(cur_wdata) * (64'd2 ** (64'd8 * off)));
    v    = 64'(cur_word) / (64'd2 ** (64'd8 * off));
    bits = 64'd8 * size;
    val  = v % (64'd2 ** bits);
    if (!cur_f3[2] && size < 64'd4 && val >= (64'd2 ** (bits - 64'd1)))
      val = val + (64'd2 ** 32) - (64'd2 ** bits);
    exp_rdata = (exp_err || cur_wen) ? 32'd0 : 32'(val);
  endtask

  task automatic set_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word);
    cur_wen = wen; cur_f3 = f3; cur_addr = addr; cur_wdata = wdata; cur_word = word;
    in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata; mem_rdata = word;
    compute_model();
  endtask

  task automatic accept();
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Checks from the cycle after the accept edge until the response is visible
  task automatic expect_resp();
    @(negedge clk);
    if (!exp_err) begin
      chk("issue_wen", 32'(mem_wen), 32'(cur_wen));
      chk("issue_ren", 32'(mem_ren), 32'(!cur_wen));
      chk("issue_addr", cur_wen ? mem_waddr : mem_raddr, exp_aligned);
      chk("issue_mask", 32'(cur_wen ? mem_wmask : mem_rmask), 32'(exp_mask));
      if (cur_wen) chk("issue_wdata", mem_wdata, exp_wdata);
      chk("issue_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("resp_valid", 32'(out_valid), 32'd1);
    chk("resp_err", 32'(out_err), 32'(exp_err));
    chk("resp_rdata", out_rdata, exp_rdata);
    chk("resp_mem_idle", {30'd0, mem_wen, mem_ren}, 32'd0);
    chk("resp_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic finish_resp(input int hold);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_rdata", out_rdata, exp_rdata);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("after_hs_valid", 32'(out_valid), 32'd0);
    chk("after_hs_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(1'b0, 3'd0, 32'h8000_0000, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_en", {30'd0, mem_wen, mem_ren}, 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    rst = 1'b0;

    // SB to the top lane
    set_req(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0);
    accept(); expect_resp(); finish_resp(0);
    // LB / LBU sign vs zero extension
    set_req(1'b0, 3'b000, 32'h8000_0001, 32'd0, 32'h1234_80FF);
    accept(); expect_resp(); finish_resp(1);
    set_req(1'b0, 3'b100, 32'h8000_0001, 32'd0, 32'h1234_80FF);
    accept(); expect_resp(); finish_resp(0);
    // LHU upper half
    set_req(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'hBEEF_0000);
    accept(); expect_resp(); finish_resp(0);
    // Misaligned LW and illegal load funct3
    set_req(1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'h5555_5555);
    accept(); expect_resp(); finish_resp(0);
    set_req(1'b0, 3'b111, 32'h8000_0004, 32'd0, 32'h5555_5555);
    accept(); expect_resp(); finish_resp(0);

    // Back-pressure: second request waits for the response handshake
    set_req(1'b0, 3'b010, 32'h8000_0010, 32'd0, 32'hCAFE_F00D);
    accept(); expect_resp();
    hold_rdata = exp_rdata;
    set_req(1'b1, 3'b001, 32'h8000_0022, 32'h0000_1234, 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rdata", out_rdata, hold_rdata);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    expect_resp(); finish_resp(0);

    // Reset during ISSUE of a store drops the transaction
    set_req(1'b1, 3'b010, 32'h8000_0020, 32'hDEAD_BEEF, 32'h0);
    accept();
    @(negedge clk);
    chk("rst_issue_wen", 32'(mem_wen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_drop_valid", 32'(out_valid), 32'd0);
      chk("rst_drop_ready", 32'(in_ready), 32'd1);
      chk("rst_drop_mem", {30'd0, mem_wen, mem_ren}, 32'd0);
    end

    // Random requests, including illegal and misaligned ones
    for (int n = 0; n < 150; n++) begin
      set_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom, $urandom);
      accept(); expect_resp(); finish_resp(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
